signal_peak_detector: RTL and testbench
=======================================

Name: signal_peak_detector

Overview:
Streaming peak detector placed directly downstream of the morphology baseline-removal filter. It consumes baseline-corrected signed samples over AXI-Stream. It finds the local maximum of each excursion above a programmable threshold and emits one {sample index, amplitude} record per excursion. A refractory window suppresses re-triggering on the same event.

Parameters:
DATA_WIDTH, 16, width of signed input samples and amplitude field
INDEX_WIDTH, 32, width of the free-running sample index counter
REFRACTORY, 72, number of accepted samples ignored after each emitted peak (0 = none)
DROP_WIDTH, 8, width of the saturating dropped-peak counter

Ports:
clk  in  1  clock
areset_n  in  1  asynchronous active-low reset
axis_in_tdata  in  DATA_WIDTH  signed baseline-corrected sample
axis_in_tvalid  in  1  input sample valid
axis_in_tready  out  1  input ready, tied to 1 when out of reset
threshold  in  DATA_WIDTH  signed detection threshold, quasi-static
axis_out_tdata  out  INDEX_WIDTH+DATA_WIDTH  {index[INDEX_WIDTH-1:0], amplitude[DATA_WIDTH-1:0]}
axis_out_tvalid  out  1  peak record valid
axis_out_tready  in  1  downstream ready
drop_count  out  DROP_WIDTH  saturating count of peaks lost to output backpressure

Behaviour:
- Reset is areset_n, asynchronous, active-low; clock is clk. In reset: state IDLE, index 0, refractory counter 0, tracked max/index 0, axis_out_tdata 0, axis_out_tvalid 0, drop_count 0, axis_in_tready 0.
- axis_in_tready is 1 in every cycle after reset release. The input is never stalled, because the upstream filter does not honour backpressure.
- Beat = axis_in_tvalid & axis_in_tready. Sample index counter increments on every beat. The first beat after reset has index 0. The counter wraps from 2^INDEX_WIDTH-1 to 0.
- All comparisons are signed on DATA_WIDTH bits. threshold is used as presented in the cycle of the beat.
- State IDLE:
  - beat with sample > threshold -> TRACK; max := sample, max_idx := index.
  - otherwise stay in IDLE.
- State TRACK:
  - beat with sample > max -> update max and max_idx. Strictly greater, so on a plateau the first occurrence wins.
  - beat with sample <= threshold -> emit the record {max_idx, max}. Then go to REFRACT with counter := REFRACTORY, or to IDLE if REFRACTORY == 0.
  - A sample > threshold but <= max leaves the state unchanged.
- State REFRACT:
  - Each beat decrements the counter; sample contents are ignored.
  - The beat that takes the counter from 1 to 0 returns to IDLE.
  - The exit beat from TRACK does not count toward REFRACTORY.
  - The next beat after the return is evaluated in IDLE.
- Emit:
  - If the output is empty (axis_out_tvalid 0), or axis_out_tready is 1 in the same cycle: axis_out_tdata is loaded and axis_out_tvalid is 1 in the cycle after the exit beat (latency 1).
  - Otherwise the record is discarded and drop_count increments, saturating at all-ones. The state transition still happens.
- Output hold: axis_out_tvalid and axis_out_tdata are stable until axis_out_tready. The handshake with no new emit clears tvalid the next cycle.
- Gaps: cycles with axis_in_tvalid 0 change nothing except the output handshake.

Decomposition:
- Shared package morph_pkg:
  - peak_state_t enum {IDLE, TRACK, REFRACT};
  - peak_record_t packed struct {index, amplitude} parameterised via localparam widths matching defaults;
  - packing helper function.
- Single module; no sub-module is natural (one FSM, one output register).

Test Plan:
- threshold=100, REFRACTORY=0, beats 0,50,150,300,200,80 -> single record {3,300}; tvalid high the cycle after beat 5; tready=1 clears it next cycle.
- Plateau: threshold=100, beats 0,200,200,50 -> record {1,200}; no second record.
- Refractory: REFRACTORY=4, threshold=100, beats 0,150,0,150,0,0,0,150,0 -> exactly two records, {1,150} and {7,150}. The pulse at index 3 is suppressed.
- Backpressure: tready=0, two separated pulses peaking 300 @ idx2 and 400 @ idx10 -> output holds {2,300}, drop_count=1; raising tready completes one transfer only.
- Signed: threshold=-50, beats -100,-20,-60 -> record {1,-20}. Also drive 8-bit drop_count past 255 dropped peaks -> holds 255.
- Reset mid-TRACK: beats 0,200 then areset_n low 3 cycles -> tvalid 0, drop_count 0. Post-reset beats 0,150,0 yield record {1,150} (index restarted at 0).

Source files
------------

// File: rtl/morph_pkg.sv
// Shared types for the morphology signal chain.
// Peak detector FSM states and the emitted peak record layout.
package morph_pkg;

  localparam int PK_DATA_W  = 16;
  localparam int PK_INDEX_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    REFRACT = 2'd2
  } peak_state_t;

  typedef struct packed {
    logic [PK_INDEX_W-1:0] index;
    logic [PK_DATA_W-1:0]  amplitude;
  } peak_record_t;

  function automatic peak_record_t pack_record(
    input logic [PK_INDEX_W-1:0] idx,
    input logic [PK_DATA_W-1:0]  amp
  );
    peak_record_t r;
    r.index     = idx;
    r.amplitude = amp;
    return r;
  endfunction

endpackage

// File: rtl/signal_peak_detector_if.sv
// AXI-Stream style valid/ready bundle.
// master drives data/valid, slave drives ready.
interface signal_peak_detector_if #(
  parameter int W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/signal_peak_detector.sv
// Streaming peak detector: emits {index, amplitude} of each
// excursion's maximum above threshold, with refractory hold-off.
module signal_peak_detector
  import morph_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int INDEX_WIDTH = 32,
  parameter int REFRACTORY  = 72,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         areset_n,
  signal_peak_detector_if.slave        axis_in,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  signal_peak_detector_if.master       axis_out,
  output logic [DROP_WIDTH-1:0]        drop_count
);

  localparam int RW =
    (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;
  localparam int OW = INDEX_WIDTH + DATA_WIDTH;

  peak_state_t state_q, state_d;

  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [INDEX_WIDTH-1:0] max_idx_q, max_idx_d;
  logic signed [DATA_WIDTH-1:0] max_q, max_d;
  logic signed [DATA_WIDTH-1:0] sample;
  logic [RW-1:0]          cnt_q, cnt_d;
  logic                   rdy_q, rdy_d;
  logic                   vld_q, vld_d;
  logic [OW-1:0]          dat_q, dat_d;
  logic [DROP_WIDTH-1:0]  drop_q, drop_d;
  logic                   beat;
  logic                   emit;
  logic                   accept;

  assign sample          = signed'(axis_in.tdata);
  assign beat            = axis_in.tvalid & rdy_q;
  assign accept          = ~vld_q | axis_out.tready;

  assign axis_in.tready  = rdy_q;
  assign axis_out.tvalid = vld_q;
  assign axis_out.tdata  = dat_q;
  assign drop_count      = drop_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    cnt_d     = cnt_q;
    rdy_d     = 1'b1;
    emit      = 1'b0;
    if (beat) begin
      idx_d = idx_q + INDEX_WIDTH'(1);
      unique case (state_q)
        IDLE: begin
          if (sample > threshold) begin
            state_d   = TRACK;
            max_d     = sample;
            max_idx_d = idx_q;
          end
        end
        TRACK: begin
          if (sample > max_q) begin
            max_d     = sample;
            max_idx_d = idx_q;
          end else if (sample <= threshold) begin
            emit    = 1'b1;
            cnt_d   = RW'(REFRACTORY);
            state_d = (REFRACTORY == 0) ? IDLE : REFRACT;
          end
        end
        REFRACT: begin
          cnt_d = cnt_q - RW'(1);
          if (cnt_q == RW'(1))
            state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A blocked emit is dropped; the held record stays intact.
  always_comb begin
    vld_d  = vld_q & ~axis_out.tready;
    dat_d  = dat_q;
    drop_d = drop_q;
    if (emit) begin
      if (accept) begin
        vld_d = 1'b1;
        dat_d = {max_idx_q, max_q};
      end else if (drop_q != '1) begin
        drop_d = drop_q + DROP_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
      dat_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      cnt_q     <= cnt_d;
      rdy_q     <= rdy_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_signal_peak_detector.sv
// Directed bench for signal_peak_detector.
// d0 runs with no refractory window, d4 with a 4-beat window.
module tb_signal_peak_detector;
  import morph_pkg::*;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  logic signed [15:0] thr = 16'sd100;
  logic [7:0] drop0, drop4;

  int n_cmp = 0;
  int n_bad = 0;

  logic [47:0] q0[$];
  logic [47:0] q4[$];

  signal_peak_detector_if #(.W(16)) i0 ();
  signal_peak_detector_if #(.W(48)) o0 ();
  signal_peak_detector_if #(.W(16)) i4 ();
  signal_peak_detector_if #(.W(48)) o4 ();

  signal_peak_detector #(
    .REFRACTORY(0)
  ) d0 (
    .clk       (clk),
    .areset_n  (areset_n),
    .axis_in   (i0),
    .threshold (thr),
    .axis_out  (o0),
    .drop_count(drop0)
  );

  signal_peak_detector #(
    .REFRACTORY(4)
  ) d4 (
    .clk       (clk),
    .areset_n  (areset_n),
    .axis_in   (i4),
    .threshold (thr),
    .axis_out  (o4),
    .drop_count(drop4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (areset_n && o0.tvalid && o0.tready)
      q0.push_back(o0.tdata);
    if (areset_n && o4.tvalid && o4.tready)
      q4.push_back(o4.tdata);
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic signed [15:0] v);
    @(negedge clk);
    i0.tdata  = v;
    i0.tvalid = 1'b1;
    i4.tdata  = v;
    i4.tvalid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i0.tvalid = 1'b0;
      i4.tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rdy(input logic r);
    o0.tready = r;
    o4.tready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset_n  = 1'b0;
    i0.tvalid = 1'b0;
    i4.tvalid = 1'b0;
    repeat (3) @(negedge clk);
    q0.delete();
    q4.delete();
    areset_n = 1'b1;
  endtask

  initial begin
    i0.tdata  = '0;
    i0.tvalid = 1'b0;
    i4.tdata  = '0;
    i4.tvalid = 1'b0;
    set_rdy(1'b1);

    // reset state
    #12;
    check("rst_tvalid", o0.tvalid, 0);
    check("rst_tdata", o0.tdata, 0);
    check("rst_drop", drop0, 0);
    check("rst_tready", i0.tready, 0);
    do_reset();
    idle(1);
    check("tready_up", i0.tready, 1);

    // basic excursion, latency 1, clear on handshake
    do_reset();
    thr = 16'sd100;
    send(0); send(50); send(150); send(300);
    send(200);
    check("t1_no_early", o0.tvalid, 0);
    send(80);
    check("t1_valid", o0.tvalid, 1);
    check("t1_rec", o0.tdata, pack_record(32'd3, 16'd300));
    idle(1);
    check("t1_clear", o0.tvalid, 0);
    idle(2);
    check("t1_count", q0.size(), 1);

    // plateau keeps first occurrence
    do_reset();
    send(0); send(200); send(200); send(50);
    idle(4);
    check("plat_count", q0.size(), 1);
    check("plat_rec", q0.size() > 0 ? q0[0] : 48'hx,
          pack_record(32'd1, 16'd200));

    // refractory window on d4
    do_reset();
    send(0); send(150); send(0); send(150);
    send(0); send(0); send(0); send(150); send(0);
    idle(3);
    check("refr_count", q4.size(), 2);
    check("refr_rec0", q4.size() > 0 ? q4[0] : 48'hx,
          pack_record(32'd1, 16'd150));
    check("refr_rec1", q4.size() > 1 ? q4[1] : 48'hx,
          pack_record(32'd7, 16'd150));
    check("norefr_count", q0.size(), 3);

    // backpressure: second peak dropped, first held
    set_rdy(1'b0);
    do_reset();
    send(0); send(200); send(300); send(0);
    send(0); send(0); send(0); send(0); send(0);
    send(200); send(400); send(0);
    idle(2);
    check("bp_valid", o0.tvalid, 1);
    check("bp_hold", o0.tdata, pack_record(32'd2, 16'd300));
    check("bp_drop", drop0, 1);
    @(negedge clk);
    i0.tvalid = 1'b0;
    i4.tvalid = 1'b0;
    set_rdy(1'b1);
    @(posedge clk);
    #1;
    check("bp_clear", o0.tvalid, 0);
    idle(3);
    check("bp_count", q0.size(), 1);
    check("bp_xfer", q0.size() > 0 ? q0[0] : 48'hx,
          pack_record(32'd2, 16'd300));

    // signed threshold
    do_reset();
    thr = -16'sd50;
    send(-16'sd100); send(-16'sd20); send(-16'sd60);
    check("sgn_valid", o0.tvalid, 1);
    check("sgn_rec", o0.tdata, pack_record(32'd1, -16'sd20));
    idle(1);

    // drop counter saturation
    thr = 16'sd100;
    set_rdy(1'b0);
    do_reset();
    send(200); send(0);
    for (int k = 1; k <= 100; k++) begin
      send(200); send(0);
    end
    check("drop_100", drop0, 100);
    for (int k = 101; k <= 255; k++) begin
      send(200); send(0);
    end
    check("drop_255", drop0, 255);
    for (int k = 0; k < 4; k++) begin
      send(200); send(0);
    end
    check("drop_sat", drop0, 255);
    check("drop_hold", o0.tdata, pack_record(32'd0, 16'd200));

    // reset while tracking
    send(0); send(200);
    @(negedge clk);
    areset_n  = 1'b0;
    i0.tvalid = 1'b0;
    i4.tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_valid", o0.tvalid, 0);
    check("mid_drop", drop0, 0);
    q0.delete();
    q4.delete();
    areset_n = 1'b1;
    set_rdy(1'b1);
    send(0); send(150); send(0);
    check("mid_rec", o0.tdata, pack_record(32'd1, 16'd150));
    idle(2);
    check("mid_count", q0.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
